// File: rtl/vc_out_scheduler_pkg.sv
// vc_out_scheduler_pkg: flit and FSM types plus the VC index width helper shared by the scheduler.
package vc_out_scheduler_pkg;
  localparam int N_VIRT_CHN = 2;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEAD_TAIL} flit_t;
  typedef enum logic {IDLE, LOCKED} sched_st_t;
  function automatic int vc_w(input int n);
    return $clog2(n > 1 ? n : 2);
  endfunction
  localparam int VC_W = vc_w(N_VIRT_CHN);
endpackage

// File: rtl/vc_prio_pick.sv
// vc_prio_pick: combinational priority picker; hi=1 favours the highest set index, hi=0 the lowest.
module vc_prio_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic         hi,
  output logic [W-1:0] idx,
  output logic         found
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++)
      if (req[hi ? i : N-1-i]) idx = W'(hi ? i : N-1-i);
  end
  assign found = |req;
endmodule

// File: rtl/vc_out_scheduler.sv
// vc_out_scheduler: packet-atomic VC grant driving the output mux select and per-VC pops.
// Define VC_SCHED_STARVE_EN to add per-VC starvation counters that override priority order.
module vc_out_scheduler
  import vc_out_scheduler_pkg::*;
#(
  parameter int N_VC       = N_VIRT_CHN,
  parameter int H_PRIORITY = 1,
  parameter int STARVE_LIM = 16,
  localparam int VW        = vc_w(N_VC)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [N_VC-1:0]   vc_valid_i,
  input  logic [2*N_VC-1:0] vc_ftype_i,
  output logic [N_VC-1:0]   vc_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [VW-1:0]     vc_sel_o,
  output logic              lock_o,
  output logic              err_o
);
  sched_st_t st, st_n;
  logic first, found, hs;
  logic [VW-1:0] win;
  flit_t ft;
  assign ft = flit_t'(vc_ftype_i[{vc_sel_o, 1'b0} +: 2]);
  assign lock_o = st == LOCKED;
  assign out_valid_o = lock_o & vc_valid_i[vc_sel_o];
  assign vc_ready_o = lock_o & out_ready_i ? N_VC'(1) << vc_sel_o : '0;
  assign hs = out_valid_o & out_ready_i;
  // first flit of a lock must open a packet; later flits must not
  assign err_o = hs & (first ? (ft == BODY || ft == TAIL) : (ft == HEAD || ft == HEAD_TAIL));
  always_comb st_n = lock_o ? (hs && (ft == TAIL || ft == HEAD_TAIL) ? IDLE : LOCKED) : (found ? LOCKED : IDLE);
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      st <= IDLE;
      vc_sel_o <= '0;
      first <= 1'b0;
    end else begin
      st <= st_n;
      if (!lock_o && found) begin
        vc_sel_o <= win;
        first <= 1'b1;
      end else if (hs) first <= 1'b0;
    end
`ifdef VC_SCHED_STARVE_EN
  localparam int CW = $clog2(STARVE_LIM + 1);
  logic [N_VC-1:0][CW-1:0] cnt;
  logic [N_VC-1:0] starved;
  logic [VW-1:0] s_idx, a_idx;
  logic s_found;
  for (genvar i = 0; i < N_VC; i++) begin : g_cnt
    assign starved[i] = vc_valid_i[i] && cnt[i] == CW'(STARVE_LIM);
    always_ff @(posedge clk or posedge arst)
      if (arst) cnt[i] <= '0;
      else if (!vc_valid_i[i] || (!lock_o && found && win == VW'(i))) cnt[i] <= '0;
      else if (!(lock_o && vc_sel_o == VW'(i)) && cnt[i] != CW'(STARVE_LIM)) cnt[i] <= cnt[i] + 1'b1;
  end
  vc_prio_pick #(.N(N_VC), .W(VW)) u_starve (.req(starved), .hi(H_PRIORITY != 0), .idx(s_idx), .found(s_found));
  vc_prio_pick #(.N(N_VC), .W(VW)) u_all (.req(vc_valid_i), .hi(H_PRIORITY != 0), .idx(a_idx), .found(found));
  assign win = s_found ? s_idx : a_idx;
`else
  vc_prio_pick #(.N(N_VC), .W(VW)) u_all (.req(vc_valid_i), .hi(H_PRIORITY != 0), .idx(win), .found(found));
`endif
endmodule

// File: tb/tb_vc_out_scheduler.sv
// tb_vc_out_scheduler: two schedulers (high- and low-index priority) fed from bench FIFOs,
// checked against a packet-level ownership model through a handshake scoreboard.
`timescale 1ns/1ps
module tb_vc_out_scheduler;
  import vc_out_scheduler_pkg::*;
  localparam int N = 2, SL = 4;
  typedef struct {int vc; logic err;} exp_t;
  logic clk = 1'b0, arst = 1'b1, ordy = 1'b0, mv = 1'b0;
  logic [N-1:0] v [2], rdy [2];
  logic [2*N-1:0] ft [2];
  logic ov [2], sel [2], lk [2], er [2];
  flit_t q [2][N][$];
  exp_t expq [2][$];
  int own [2], age [2][N];
  logic first_m [2], exp_lk [2], exp_ov [2];
  logic [N-1:0] exp_r [2];
  int n_chk = 0, n_fail = 0;

  vc_out_scheduler #(.N_VC(N), .H_PRIORITY(1), .STARVE_LIM(SL)) u_hi (
    .clk(clk), .arst(arst), .vc_valid_i(v[0]), .vc_ftype_i(ft[0]), .vc_ready_o(rdy[0]),
    .out_valid_o(ov[0]), .out_ready_i(ordy), .vc_sel_o(sel[0]), .lock_o(lk[0]), .err_o(er[0]));
  vc_out_scheduler #(.N_VC(N), .H_PRIORITY(0), .STARVE_LIM(SL)) u_lo (
    .clk(clk), .arst(arst), .vc_valid_i(v[1]), .vc_ftype_i(ft[1]), .vc_ready_o(rdy[1]),
    .out_valid_o(ov[1]), .out_ready_i(ordy), .vc_sel_o(sel[1]), .lock_o(lk[1]), .err_o(er[1]));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // index 0 models the high-index-wins scheduler, index 1 the low-index-wins one
  function automatic int pick(input int d, input logic [N-1:0] m);
    int w = -1;
    for (int i = 0; i < N; i++) if (m[i] && (d == 0 || w < 0)) w = i;
    return w;
  endfunction

  task automatic model(input int d);
    int nxt, w;
    logic [N-1:0] st;
    flit_t f;
    nxt = own[d];
    w = -1;
    st = '0;
    exp_lk[d] = own[d] >= 0;
    exp_ov[d] = own[d] >= 0 && v[d][own[d]];
    exp_r[d] = '0;
    if (own[d] < 0) begin
`ifdef VC_SCHED_STARVE_EN
      for (int i = 0; i < N; i++) st[i] = v[d][i] && age[d][i] == SL;
      w = pick(d, st);
`endif
      if (w < 0) w = pick(d, v[d]);
      if (w >= 0) begin
        nxt = w;
        first_m[d] = 1'b1;
      end
    end else begin
      if (ordy) exp_r[d][own[d]] = 1'b1;
      if (v[d][own[d]] && ordy) begin
        f = q[d][own[d]][0];
        expq[d].push_back('{own[d], first_m[d] ? (f == BODY || f == TAIL) : (f == HEAD || f == HEAD_TAIL)});
        first_m[d] = 1'b0;
        if (f == TAIL || f == HEAD_TAIL) nxt = -1;
      end
    end
`ifdef VC_SCHED_STARVE_EN
    for (int i = 0; i < N; i++)
      if (!v[d][i] || (own[d] < 0 && w == i)) age[d][i] = 0;
      else if (own[d] != i && age[d][i] < SL) age[d][i]++;
`endif
    own[d] = nxt;
  endtask

  task automatic step(input logic r, input logic [N-1:0] gap);
    @(negedge clk);
    ordy = r;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        v[d][i] = q[d][i].size() > 0 && !gap[i];
        ft[d][2*i +: 2] = q[d][i].size() > 0 ? q[d][i][0] : HEAD;
      end
    #2;
    for (int d = 0; d < 2; d++) model(d);
    mv = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++)
        if (rdy[d][i] && v[d][i]) void'(q[d][i].pop_front());
  endtask

  task automatic add_pkt(input int vc, input int len);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < len; k++)
        q[d][vc].push_back(len == 1 ? HEAD_TAIL : k == 0 ? HEAD : k == len - 1 ? TAIL : BODY);
  endtask

  task automatic add_raw(input int vc, input flit_t f);
    for (int d = 0; d < 2; d++) q[d][vc].push_back(f);
  endtask

  function automatic int pending();
    int p = 0;
    for (int d = 0; d < 2; d++) begin
      p += own[d] >= 0 ? 1 : 0;
      for (int i = 0; i < N; i++) p += q[d][i].size();
    end
    return p;
  endfunction

  task automatic drain(input string name);
    for (int c = 0; c < 400 && pending() > 0; c++) step(1'b1, '0);
    chk({name, "_drain_left"}, pending(), 0);
    step(1'b1, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 arst = 1'b1;
    ordy = 1'b0;
    for (int d = 0; d < 2; d++) begin
      v[d] = '0;
      ft[d] = '0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_lock[%0d]", d), lk[d], 0);
      chk($sformatf("rst_ready[%0d]", d), rdy[d], 0);
      chk($sformatf("rst_err[%0d]", d), er[d], 0);
      chk($sformatf("rst_sel[%0d]", d), sel[d], 0);
      chk($sformatf("rst_valid[%0d]", d), ov[d], 0);
      own[d] = -1;
      first_m[d] = 1'b0;
      expq[d].delete();
      for (int i = 0; i < N; i++) begin
        q[d][i].delete();
        age[d][i] = 0;
      end
    end
    @(negedge clk);
    arst = 1'b0;
  endtask

  // monitor: per-cycle lock/ready/valid against the model, flit order and err via the scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    #3;
    if (mv && !arst) begin
      mv = 1'b0;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("lock[%0d]", d), lk[d], exp_lk[d]);
        chk($sformatf("ready[%0d]", d), rdy[d], exp_r[d]);
        chk($sformatf("out_valid[%0d]", d), ov[d], exp_ov[d]);
        if (ov[d] && ordy) begin
          chk($sformatf("hs_expected[%0d]", d), expq[d].size() > 0, 1);
          if (expq[d].size() > 0) begin
            e = expq[d].pop_front();
            chk($sformatf("hs_sel[%0d]", d), sel[d], e.vc);
            chk($sformatf("hs_err[%0d]", d), er[d], e.err);
          end
        end else chk($sformatf("err_no_hs[%0d]", d), er[d], 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      v[d] = '0;
      ft[d] = '0;
    end
    do_reset();
    add_pkt(0, 4);
    step(1'b1, '0);
    step(1'b1, '0);
    add_pkt(1, 1);
    drain("atomic");
    add_pkt(0, 1);
    add_pkt(1, 1);
    drain("prio");
    add_pkt(0, 4);
    step(1'b1, '0);
    step(1'b1, '0);
    repeat (5) step(1'b0, '0);
    repeat (3) step(1'b1, 2'b01);
    drain("stall");
    add_raw(0, BODY);
    add_raw(0, TAIL);
    drain("err_body");
    add_raw(0, HEAD);
    add_raw(0, HEAD);
    add_raw(0, TAIL);
    add_raw(1, HEAD_TAIL);
    drain("err_head");
    for (int k = 0; k < 12; k++) add_pkt(1, 1);
    add_pkt(0, 2);
    drain("starve");
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) add_pkt(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 5)));
      step($urandom_range(0, 3) != 0, ($urandom_range(0, 9) == 0) ? N'($urandom_range(1, 3)) : '0);
    end
    drain("random");
    add_pkt(1, 6);
    repeat (3) step(1'b1, '0);
    chk("pre_reset_lock", lk[0], 1);
    chk("pre_reset_sel", sel[0], 1);
    do_reset();
    add_pkt(0, 1);
    add_pkt(1, 2);
    drain("post_reset");
    for (int d = 0; d < 2; d++) chk($sformatf("scoreboard_left[%0d]", d), expq[d].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
